// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the multicycle control unit (master) and the CPU
// datapath: ROM, PC, RAM, ALU/accumulator and UART transmitter (slave).
interface multicycle_control_fsm_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
);
  logic              run;
  logic [ADDR_W+2:0] instruction;
  logic [DATA_W-1:0] acc_data;
  logic              uart_busy;
  logic [1:0]        alu_op;
  logic              acc_write;
  logic              load_sel;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic              pc_write;
  logic              pc_inc;
  logic [ADDR_W-1:0] new_pc;
  logic              uart_send;
  logic              halted;

  modport master (
    input  run, instruction, acc_data, uart_busy,
    output alu_op, acc_write, load_sel, mem_read, mem_write, mem_addr,
           pc_write, pc_inc, new_pc, uart_send, halted
  );

  modport slave (
    output run, instruction, acc_data, uart_busy,
    input  alu_op, acc_write, load_sel, mem_read, mem_write, mem_addr,
           pc_write, pc_inc, new_pc, uart_send, halted
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Fetch/decode/execute control unit for the accumulator CPU with an internal
// instruction register, configurable RAM read latency and UART-busy handshake.
//
// state  | meaning
// IDLE   | waiting for run, all outputs low
// FETCH  | latch ROM word into IR
// DECODE | route by opcode, preload RAM latency counter
// MEM    | RAM read in flight for MEM_LAT cycles
// WB     | accumulator write-back (LOAD/ADD/SUB), PC+1
// EXEC   | single-cycle STORE/JMP/JZ/NOP
// UART   | wait for transmitter, then one-cycle send strobe
// HALT   | halted, left only through reset
module multicycle_control_fsm #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 5,
  parameter int MEM_LAT = 1
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  multicycle_control_fsm_if.master bus
);
  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [DATA_W-1:0] ACC_ZERO = '0;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_STORE = 3'b010;
  localparam logic [2:0] OP_ADD   = 3'b011;
  localparam logic [2:0] OP_SUB   = 3'b100;
  localparam logic [2:0] OP_JMP   = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_OUT   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM, S_WB, S_EXEC, S_UART, S_HALT
  } state_t;

  state_t            r_state;
  logic [ADDR_W+2:0] r_ir;
  logic [CNT_W-1:0]  r_cnt;

  logic [2:0]        w_op;
  logic [ADDR_W-1:0] w_arg;
  logic              w_acc_zero;
  state_t            w_after;

  logic [1:0]        w_alu_op;
  logic              w_acc_write;
  logic              w_load_sel;
  logic              w_mem_read;
  logic              w_mem_write;
  logic [ADDR_W-1:0] w_addr;
  logic              w_pc_write;
  logic              w_pc_inc;
  logic              w_uart_send;
  logic              w_halted;

  assign w_op       = r_ir[ADDR_W+2:ADDR_W];
  assign w_arg      = r_ir[ADDR_W-1:0];
  assign w_acc_zero = (bus.acc_data == ACC_ZERO);
  assign w_after    = bus.run ? S_FETCH : S_IDLE;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE:   if (bus.run) r_state <= S_FETCH;
        S_FETCH: begin
          r_ir    <= bus.instruction;
          r_state <= S_DECODE;
        end
        S_DECODE: begin
          case (w_op)
            OP_LOAD, OP_ADD, OP_SUB: begin
              r_state <= S_MEM;
              r_cnt   <= CNT_LOAD;
            end
            OP_OUT:  r_state <= S_UART;
            OP_NOP:  r_state <= (&w_arg) ? S_HALT : S_EXEC;
            default: r_state <= S_EXEC;
          endcase
        end
        S_MEM: begin
          if (r_cnt == '0) r_state <= S_WB;
          else             r_cnt   <= r_cnt - CNT_ONE;
        end
        S_WB, S_EXEC: r_state <= w_after;
        S_UART:   if (!bus.uart_busy) r_state <= w_after;
        S_HALT:   r_state <= S_HALT;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes depend on state/IR only, except JZ (acc_data) and OUT (uart_busy).
  always_comb begin
    w_alu_op    = 2'b00;
    w_acc_write = 1'b0;
    w_load_sel  = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_pc_write  = 1'b0;
    w_pc_inc    = 1'b0;
    w_uart_send = 1'b0;
    w_halted    = 1'b0;
    w_addr      = (r_state == S_IDLE) ? '0 : w_arg;
    case (r_state)
      S_MEM: w_mem_read = 1'b1;
      S_WB: begin
        w_mem_read  = 1'b1;
        w_acc_write = 1'b1;
        w_pc_inc    = 1'b1;
        w_load_sel  = (w_op == OP_LOAD);
        w_alu_op    = (w_op == OP_SUB) ? 2'b01 : 2'b00;
      end
      S_EXEC: begin
        case (w_op)
          OP_STORE: begin
            w_mem_write = 1'b1;
            w_pc_inc    = 1'b1;
          end
          OP_JMP: w_pc_write = 1'b1;
          OP_JZ: begin
            if (w_acc_zero) w_pc_write = 1'b1;
            else            w_pc_inc   = 1'b1;
          end
          OP_NOP:  w_pc_inc = 1'b1;
          default: ;
        endcase
      end
      S_UART: begin
        if (!bus.uart_busy) begin
          w_uart_send = 1'b1;
          w_pc_inc    = 1'b1;
        end
      end
      S_HALT:  w_halted = 1'b1;
      default: ;
    endcase
  end

  assign bus.alu_op    = w_alu_op;
  assign bus.acc_write = w_acc_write;
  assign bus.load_sel  = w_load_sel;
  assign bus.mem_read  = w_mem_read;
  assign bus.mem_write = w_mem_write;
  assign bus.mem_addr  = w_addr;
  assign bus.pc_write  = w_pc_write;
  assign bus.pc_inc    = w_pc_inc;
  assign bus.new_pc    = w_addr;
  assign bus.uart_send = w_uart_send;
  assign bus.halted    = w_halted;
endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Multi-cycle control unit for the accumulator CPU. It replaces single-cycle combinational decode with an explicit fetch/decode/execute state machine. Each instruction is latched into an internal instruction register, so decode is stable for the whole instruction. The unit adds three capabilities:
- parametrised data/address widths;
- a configurable RAM read latency;
- a UART-busy handshake, plus run/halt control.

It sits between the instruction ROM, PC, RAM, ALU/accumulator and UART transmitter.

## Interface
- DATA_W, 8, accumulator/data width
- ADDR_W, 5, RAM and PC address width; operand field width
- MEM_LAT, 1, RAM read latency in cycles (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; permits fetching the next instruction
- instruction  in  3+ADDR_W  from instruction ROM at current PC; [ADDR_W+2:ADDR_W]=opcode, [ADDR_W-1:0]=operand
- acc_data  in  DATA_W  accumulator value, for the JZ decision
- uart_busy  in  1  UART transmitter cannot accept a byte
- alu_op  out  2  00=add, 01=sub
- acc_write  out  1  load accumulator this cycle
- load_sel  out  1  accumulator source = RAM data (LOAD) instead of ALU
- mem_read  out  1  RAM read enable
- mem_write  out  1  RAM write enable (accumulator → RAM)
- mem_addr  out  ADDR_W  RAM address = IR operand
- pc_write  out  1  PC ← new_pc
- pc_inc  out  1  PC ← PC+1 (wraps modulo 2^ADDR_W)
- new_pc  out  ADDR_W  jump target = IR operand
- uart_send  out  1  single-cycle strobe, accumulator byte → UART
- halted  out  1  HALT executed

## Operation
- Registers:
  - state;
  - IR (3+ADDR_W bits);
  - latency counter (ceil(log2(MEM_LAT+1)) bits).
- All outputs are decoded from state and IR only. The exceptions are JZ (acc_data) and OUT (uart_busy).
- States and transitions:
  - IDLE: all outputs 0. Go to FETCH when run=1.
  - FETCH: IR ← instruction. Go to DECODE.
  - DECODE: no strobes; mem_addr/new_pc already driven from IR. Routing by opcode:
    - 001/011/100 → MEM, counter ← MEM_LAT−1;
    - 111 → UART;
    - 000 with operand all-ones → HALT;
    - everything else → EXEC.
  - MEM: mem_read=1. Counter decrements each cycle; go to WB when it reads 0.
  - WB: mem_read=1, acc_write=1, pc_inc=1.
    - LOAD: load_sel=1.
    - ADD: alu_op=00.
    - SUB: alu_op=01.
  - EXEC: single cycle, then next-state rule.
    - STORE (010): mem_write=1, pc_inc=1.
    - JMP (101): pc_write=1.
    - JZ (110): pc_write=1 if acc_data==0 (all DATA_W bits), else pc_inc=1.
    - NOP (000, other operands): pc_inc=1.
  - UART: if uart_busy=1, hold with no strobes. If uart_busy=0: uart_send=1 and pc_inc=1 for exactly one cycle, then next-state rule.
  - HALT: halted=1 and all other strobes 0. Exit only via reset; run is ignored.
- Next-state rule, applied after WB, EXEC and UART completion: FETCH if run=1, else IDLE.
- pc_write and pc_inc are never both 1. mem_read and mem_write are never both 1.
- mem_addr and new_pc equal the IR operand in every state except IDLE. In IDLE they are 0.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, IR=0, counter=0.
  - All outputs are 0 while reset is asserted and on release.
  - Reset mid-instruction aborts it immediately. No partial strobe survives past reset assertion.
- Cycles per instruction, counted from FETCH:
  - LOAD/ADD/SUB: 3+MEM_LAT (FETCH, DECODE, MEM×MEM_LAT, WB).
  - STORE/JMP/JZ/NOP: 3.
  - OUT: 3 + number of cycles uart_busy=1 is sampled in UART.
  - HALT: 2, then holds.
- RAM data is consumed in WB, MEM_LAT cycles after mem_read first rises. mem_read stays high continuously from MEM through WB.
- instruction is sampled only in FETCH. ROM changes in other states are ignored.
- acc_data is sampled only in EXEC for JZ.
- uart_busy rising in the same cycle the strobe would issue: no strobe, keep waiting.
- run deasserted mid-instruction: the instruction completes, then IDLE. The PC update still occurs.
- PC wrap at 2^ADDR_W−1 is handled by the PC register. This block only issues pc_inc.

## Test plan
- Reset then run=1, MEM_LAT=1, instruction=LOAD 5 (001_00101):
  - FETCH→DECODE→MEM→WB;
  - in WB, mem_addr=5, mem_read=1, acc_write=1, load_sel=1, pc_inc=1;
  - the next cycle is FETCH.
- MEM_LAT=3, SUB 9:
  - mem_read is high for 4 consecutive cycles;
  - acc_write and alu_op=01 occur only in the 4th;
  - total 6 cycles.
- JZ 17 (110_10001):
  - with acc_data=0: pc_write=1, new_pc=17;
  - with acc_data=0x01: pc_inc=1, pc_write=0;
  - DATA_W=16 with acc_data=0x0100 → not zero.
- OUT with uart_busy=1 for 4 cycles after DECODE:
  - no uart_send during the busy cycles;
  - single uart_send+pc_inc on the first cycle uart_busy=0;
  - total 7 cycles.
- Instruction 000_11111 (HALT):
  - halted=1 permanently, all strobes 0, run ignored;
  - reset clears halted and returns the FSM to IDLE.
- Reset asserted during MEM of an ADD, and run dropped during a STORE:
  - reset case: outputs 0 immediately, IDLE after release;
  - STORE case: mem_write+pc_inc still issue, then IDLE.
